tx_freq: RTL and testbench

Transmit-side framer for the host serial link. On a start pulse it latches a 32-bit binary frequency word and a 32-bit binary code-rate word. Both values are in 0.1 units. It converts each word to 8 packed-BCD digits and emits 8 bytes, one at a time, to the UART transmitter over a pi_flag/pi_data strobe with a tx_done return handshake. The frame format is identical to the one the host sends for frequency/code-rate configuration, so the host can read back the active settings.

---
 rtl/tx_freq_pkg.sv | 41 ++++
 rtl/tx_freq_bin2bcd_seq.sv | 66 ++++++
 rtl/tx_freq.sv | 150 +++++++++++++++
 tb/tb_tx_freq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_freq_pkg.sv
// Shared definitions for the frequency / code-rate frame path: FSM encoding,
// BCD sizing, saturation limit and the byte-order mapping of a frame.
package tx_freq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } state_e;

  localparam int unsigned BIN_W       = 32;
  localparam int unsigned BCD_DIGITS  = 8;
  localparam int unsigned BCD_W       = 4 * BCD_DIGITS;
  localparam int unsigned FRAME_BYTES = 8;

  localparam logic [BIN_W-1:0] BCD_MAX = 32'd99_999_999;

  // Frame layout: four bytes of frequency, then four bytes of code rate,
  // each value sent most-significant digit pair first.
  localparam int unsigned BYTES_PER_VALUE = BCD_DIGITS / 2;
  localparam int unsigned FREQ_BYTE0      = 0;
  localparam int unsigned CR_BYTE0        = FREQ_BYTE0 + BYTES_PER_VALUE;

  function automatic logic [BIN_W-1:0] clamp_bcd_max(input logic [BIN_W-1:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

  // Byte idx of a frame built from the two packed-BCD values.
  function automatic logic [7:0] frame_byte(input logic [BCD_W-1:0] f_bcd,
                                            input logic [BCD_W-1:0] c_bcd,
                                            input logic [2:0]       idx);
    logic [BCD_W-1:0] sel;
    logic [1:0]       pair;
    sel  = (idx < 3'(CR_BYTE0)) ? f_bcd : c_bcd;
    pair = 2'(BYTES_PER_VALUE - 1) - idx[1:0];
    return sel[{pair, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/tx_freq_bin2bcd_seq.sv
// Sequential double-dabble: 32-bit binary to 8 packed-BCD digits.
// start_i loads the operand; done_o pulses exactly BIN_W cycles later with
// bcd_o valid, and bcd_o holds until the next start_i.
module bin2bcd_seq
  import tx_freq_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic [BCD_W-1:0] bcd_o,
  output logic             done_o
);

  localparam int unsigned ITER_W = $clog2(BIN_W);

  logic [BIN_W-1:0]       bin_q;
  logic [BCD_W-1:0]       bcd_q;
  logic [ITER_W-1:0]      iter_q;
  logic                   run_q;
  logic                   done_q;
  logic [BCD_W-1:0]       bcd_adj_d;
  logic [BCD_W+BIN_W-1:0] shift_d;

  // Add 3 to every digit >= 5, then shift the combined {bcd, bin} left by one.
  always_comb begin
    bcd_adj_d = bcd_q;
    for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) begin
        bcd_adj_d[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
      end
    end
    shift_d = {bcd_adj_d, bin_q} << 1;
  end

  // Iteration sequencer: load on start, one adjust-and-shift per clock.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      iter_q <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        bin_q  <= bin_i;
        bcd_q  <= '0;
        iter_q <= '0;
        run_q  <= 1'b1;
      end else if (run_q) begin
        bcd_q  <= shift_d[BCD_W+BIN_W-1:BIN_W];
        bin_q  <= shift_d[BIN_W-1:0];
        iter_q <= iter_q + 1'b1;
        if (iter_q == ITER_W'(BIN_W - 1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bcd_o  = bcd_q;
  assign done_o = done_q;

endmodule

// File: rtl/tx_freq.sv
// Transmit framer: latches frequency and code rate, converts both to BCD
// and streams the 8-byte frame to the UART transmitter with a per-byte
// tx_done handshake and a timeout abort.
module tx_freq
  import tx_freq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [31:0] freq_in,
  input  logic [31:0] code_rate_in,
  input  logic        tx_done,
  output logic        pi_flag,
  output logic [7:0]  pi_data,
  output logic        busy,
  output logic        send_done,
  output logic        sat_flag,
  output logic        tx_err
);

  localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]      IDX_LAST = 3'(FRAME_BYTES - 1);

  state_e            state_q;
  logic [2:0]        idx_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              pi_flag_q;
  logic [7:0]        pi_data_q;
  logic              busy_q;
  logic              send_done_q;
  logic              sat_q;
  logic              tx_err_q;

  logic              conv_start_d;
  logic              sat_d;
  logic [BIN_W-1:0]  freq_clamp_d;
  logic [BIN_W-1:0]  cr_clamp_d;
  logic [BCD_W-1:0]  freq_bcd;
  logic [BCD_W-1:0]  cr_bcd;
  logic              freq_done;
  logic              cr_done;

  // Start acceptance and input saturation.
  always_comb begin
    conv_start_d = start && (state_q == ST_IDLE);
    freq_clamp_d = clamp_bcd_max(freq_in);
    cr_clamp_d   = clamp_bcd_max(code_rate_in);
    sat_d        = (freq_in > BCD_MAX) || (code_rate_in > BCD_MAX);
  end

  // The converters hold the latched, clamped operands for the frame.
  bin2bcd_seq u_freq_bcd (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start_i   (conv_start_d),
    .bin_i     (freq_clamp_d),
    .bcd_o     (freq_bcd),
    .done_o    (freq_done)
  );

  bin2bcd_seq u_cr_bcd (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start_i   (conv_start_d),
    .bin_i     (cr_clamp_d),
    .bcd_o     (cr_bcd),
    .done_o    (cr_done)
  );

  // Frame FSM with registered outputs. pi_flag is high exactly while the FSM
  // sits in SEND, so the byte is loaded on the transition into SEND.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      to_cnt_q    <= '0;
      pi_flag_q   <= 1'b0;
      pi_data_q   <= '0;
      busy_q      <= 1'b0;
      send_done_q <= 1'b0;
      sat_q       <= 1'b0;
      tx_err_q    <= 1'b0;
    end else begin
      pi_flag_q   <= 1'b0;
      send_done_q <= 1'b0;
      tx_err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sat_q    <= sat_d;
            idx_q    <= '0;
            to_cnt_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (freq_done && cr_done) begin
            pi_data_q <= frame_byte(freq_bcd, cr_bcd, idx_q);
            pi_flag_q <= 1'b1;
            to_cnt_q  <= '0;
            state_q   <= ST_SEND;
          end
        end
        ST_SEND: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tx_done) begin
            if (idx_q == IDX_LAST) begin
              send_done_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              idx_q     <= idx_q + 3'd1;
              pi_data_q <= frame_byte(freq_bcd, cr_bcd, idx_q + 3'd1);
              pi_flag_q <= 1'b1;
              to_cnt_q  <= '0;
              state_q   <= ST_SEND;
            end
          end else if (to_cnt_q == TO_LAST) begin
            tx_err_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign pi_flag   = pi_flag_q;
  assign pi_data   = pi_data_q;
  assign busy      = busy_q;
  assign send_done = send_done_q;
  assign sat_flag  = sat_q;
  assign tx_err    = tx_err_q;

endmodule

// File: tb/tb_tx_freq.sv
// Bench for tx_freq: expected frame bytes are derived arithmetically from
// the input values and queued; a monitor pops and compares on every pi_flag.
module tb_tx_freq;

  localparam int unsigned TO = 100;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] freq_in = '0;
  logic [31:0] code_rate_in = '0;
  logic        tx_done = 1'b0;
  logic        pi_flag;
  logic [7:0]  pi_data;
  logic        busy;
  logic        send_done;
  logic        sat_flag;
  logic        tx_err;

  tx_freq #(.TIMEOUT_CYC(TO)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .start        (start),
    .freq_in      (freq_in),
    .code_rate_in (code_rate_in),
    .tx_done      (tx_done),
    .pi_flag      (pi_flag),
    .pi_data      (pi_data),
    .busy         (busy),
    .send_done    (send_done),
    .sat_flag     (sat_flag),
    .tx_err       (tx_err)
  );

  always #10 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int pi_count = 0;
  int sd_count = 0;
  int err_count = 0;
  int last_pi_cyc = 0;
  int err_lat = 0;
  logic err_busy = 1'b0;
  int resp_n = 0;
  int withhold_at = -1;
  int tx_delay = 10;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference: clamp, then pick decimal digits with division.
  function automatic logic [7:0] model_byte(input logic [31:0] f, input logic [31:0] c, input int k);
    longint unsigned v, div;
    int unsigned ld, hi, lo;
    v = (k < 4) ? {32'd0, f} : {32'd0, c};
    if (v > 64'd99_999_999) v = 64'd99_999_999;
    ld = 6 - 2 * (k % 4);
    div = 1;
    for (int unsigned i = 0; i < ld; i++) div = div * 10;
    lo = int'((v / div) % 10);
    hi = int'((v / (div * 10)) % 10);
    return {hi[3:0], lo[3:0]};
  endfunction

  function automatic logic model_sat(input logic [31:0] f, input logic [31:0] c);
    return (f > 32'd99_999_999) || (c > 32'd99_999_999);
  endfunction

  task automatic push_frame(input logic [31:0] f, input logic [31:0] c, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(model_byte(f, c, k));
  endtask

  // Cycle counter (value after each posedge).
  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  // Monitor: scoreboard pop on each byte strobe, event counters.
  initial forever begin
    logic [7:0] expb;
    @(negedge sys_clk);
    if (pi_flag) begin
      pi_count++;
      last_pi_cyc = cyc;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pi_data_unexpected: got %02h, required no byte", pi_data);
      end else begin
        expb = exp_q.pop_front();
        check("pi_data", pi_data, expb);
      end
    end
    if (send_done) sd_count++;
    if (tx_err) begin
      err_count++;
      err_lat = cyc - last_pi_cyc;
      err_busy = busy;
    end
  end

  // UART model: answers each byte with tx_done after tx_delay clocks.
  initial forever begin
    int cur;
    @(negedge sys_clk);
    if (sys_rst_n && pi_flag) begin
      cur = resp_n;
      resp_n++;
      if (cur != withhold_at) begin
        repeat (tx_delay) @(posedge sys_clk);
        #1 tx_done = 1'b1;
        @(posedge sys_clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: got no end, required finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic [31:0] f, input logic [31:0] c);
    @(negedge sys_clk);
    freq_in = f;
    code_rate_in = c;
    start = 1'b1;
    @(posedge sys_clk);
    #1 start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge sys_clk);
    while (busy && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    check("frame_end_bound", busy, 0);
  endtask

  task automatic wait_resp(input int target);
    int n = 0;
    while (resp_n < target && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    check("byte_reached_bound", (resp_n >= target), 1);
  endtask

  task automatic run_frame(input logic [31:0] f, input logic [31:0] c);
    int n = 0;
    int sd0, pc0;
    sd0 = sd_count;
    pc0 = pi_count;
    push_frame(f, c, 8);
    pulse_start(f, c);
    @(negedge sys_clk);
    check("busy_after_start", busy, 1);
    check("sat_flag_frame", sat_flag, model_sat(f, c));
    while (!pi_flag && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    check("first_pi_latency", cyc - start_cyc, 33);
    wait_idle();
    check("bytes_per_frame", pi_count - pc0, 8);
    check("send_done_count", sd_count - sd0, 1);
    check("sat_flag_sticky", sat_flag, model_sat(f, c));
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int base, sd0, pc0, ec0;
    logic [31:0] f, c;

    repeat (3) @(negedge sys_clk);
    check("reset_outputs", {pi_flag, pi_data, busy, send_done, sat_flag, tx_err}, 0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    tx_delay = 10;
    run_frame(32'd12_345_678, 32'd1_000);
    run_frame(32'hFFFF_FFFF, 32'd100_000_000);
    run_frame(32'd0, 32'd9);
    run_frame(32'd55, 32'd4_321);

    // Start re-pulsed during CONV and during WAIT of byte 3.
    base = resp_n;
    sd0 = sd_count;
    pc0 = pi_count;
    push_frame(32'd87_654_321, 32'd2_468, 8);
    pulse_start(32'd87_654_321, 32'd2_468);
    repeat (10) @(negedge sys_clk);
    pulse_start(32'd11_111_111, 32'd22);
    wait_resp(base + 4);
    repeat (2) @(negedge sys_clk);
    pulse_start(32'd33_333_333, 32'd44);
    wait_idle();
    check("restart_bytes", pi_count - pc0, 8);
    check("restart_send_done", sd_count - sd0, 1);
    check("restart_queue", exp_q.size(), 0);
    exp_q.delete();

    // Timeout: byte 2 never acknowledged.
    repeat (30) @(negedge sys_clk);
    withhold_at = resp_n + 2;
    sd0 = sd_count;
    pc0 = pi_count;
    ec0 = err_count;
    push_frame(32'd5_000_001, 32'd77, 3);
    pulse_start(32'd5_000_001, 32'd77);
    wait_idle();
    check("timeout_bytes", pi_count - pc0, 3);
    check("timeout_tx_err", err_count - ec0, 1);
    check("timeout_no_send_done", sd_count - sd0, 0);
    check("timeout_latency", err_lat, TO + 1);
    check("timeout_busy_low", err_busy, 0);
    check("timeout_queue", exp_q.size(), 0);
    exp_q.delete();
    withhold_at = -1;
    run_frame(32'd31_415_926, 32'd27_182);

    // Asynchronous reset during WAIT of byte 5.
    repeat (30) @(negedge sys_clk);
    base = resp_n;
    push_frame(32'd123_456_789, 32'd65_536, 6);
    pulse_start(32'd123_456_789, 32'd65_536);
    wait_resp(base + 6);
    repeat (2) @(negedge sys_clk);
    #3 sys_rst_n = 1'b0;
    #1 check("midframe_reset_outputs", {pi_flag, pi_data, busy, send_done, sat_flag, tx_err}, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    pc0 = pi_count;
    repeat (150) @(negedge sys_clk);
    check("no_bytes_after_reset", pi_count - pc0, 0);
    check("idle_after_reset", busy, 0);
    check("reset_queue", exp_q.size(), 0);
    exp_q.delete();
    run_frame(32'd2_020, 32'd99_999_999);

    // Randomized frames.
    for (int i = 0; i < 6; i++) begin
      f = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 99_999_999);
      c = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 99_999_999);
      tx_delay = $urandom_range(1, 12);
      repeat (20) @(negedge sys_clk);
      run_frame(f, c);
    end

    repeat (20) @(negedge sys_clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
